// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared types, constants and the imem window test for the fetch stage.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_VEC  = 32'h0400_0000;
    localparam logic [31:0] DEF_IMEM_BASE  = 32'h0400_0000;
    localparam logic [31:0] DEF_TRAP_VEC   = 32'h0400_0100;
    localparam int          DEF_IMEM_WORDS = 1024;

    // 33-bit compare so a window ending at 2^32 cannot wrap
    function automatic logic in_window(input logic [31:0] a, input logic [31:0] base, input int words);
        return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < ({1'b0, base} + (33'(words) << 2)));
    endfunction

endpackage

// File: rtl/if_pc_fetch_if.sv
// if_pc_fetch_if: control inputs, imem bus and decode-facing outputs of the fetch stage.
interface if_pc_fetch_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] Addr;
    logic [31:0] Instr;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        misalign_exc;
    logic        fetch_fault;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_target, Instr,
        output Addr, if_instr, if_pc, if_pc_plus4, if_valid,
               misalign_exc, fetch_fault, fault_addr, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_target, Instr,
        input  Addr, if_instr, if_pc, if_pc_plus4, if_valid,
               misalign_exc, fetch_fault, fault_addr, fetch_count
    );
endinterface

// File: rtl/if_next_pc_sel.sv
// if_next_pc_sel: priority mux choosing the next PC and flagging trap, fault and accepted redirects.
module if_next_pc_sel
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
    parameter int          IMEM_WORDS = DEF_IMEM_WORDS,
    parameter logic [31:0] TRAP_VEC   = DEF_TRAP_VEC
) (
    input  state_t      state,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        in_win,
    output logic [31:0] next_pc,
    output logic        take,
    output logic        trap,
    output logic        fault
);
    logic mis;
    logic tgt_win;

    assign mis     = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign tgt_win = in_window(redirect_target, IMEM_BASE, IMEM_WORDS);

    // in FAULT only a trap or an in-window aligned target can restart fetch
    always_comb begin
        take    = state == RUN ? redirect_valid : state == FAULT && (mis || (redirect_valid && tgt_win));
        trap    = take && mis;
        fault   = state == RUN && !in_win && !redirect_valid;
        next_pc = trap ? TRAP_VEC
                : take ? redirect_target
                : (state == RUN && in_win && !stall) ? pc + 32'd4
                : pc;
    end
endmodule

// File: rtl/if_pc_fetch.sv
// if_pc_fetch: PC register and fetch sequencer feeding instruction memory and decode.
module if_pc_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC  = DEF_RESET_VEC,
    parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
    parameter int          IMEM_WORDS = DEF_IMEM_WORDS,
    parameter logic [31:0] TRAP_VEC   = DEF_TRAP_VEC
) (
    input logic           clk,
    input logic           rst,
    if_pc_fetch_if.master bus
);
    state_t      state, state_n;
    logic [31:0] pc, next_pc;
    logic        in_win, valid, take, trap, fault;

    assign in_win = in_window(pc, IMEM_BASE, IMEM_WORDS);

    if_next_pc_sel #(
        .IMEM_BASE (IMEM_BASE),
        .IMEM_WORDS(IMEM_WORDS),
        .TRAP_VEC  (TRAP_VEC)
    ) u_sel (
        .state          (state),
        .pc             (pc),
        .stall          (bus.stall),
        .redirect_valid (bus.redirect_valid),
        .redirect_target(bus.redirect_target),
        .in_win         (in_win),
        .next_pc        (next_pc),
        .take           (take),
        .trap           (trap),
        .fault          (fault)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= BOOT;
        else     state <= state_n;

    always_comb
        state_n = state == BOOT ? RUN : fault ? FAULT : take ? RUN : state;

    always_comb begin
        valid            = state == RUN && in_win;
        bus.if_valid     = valid;
        bus.Addr         = pc;
        bus.if_pc        = pc;
        bus.if_pc_plus4  = pc + 32'd4;
        bus.if_instr     = valid ? bus.Instr : NOP_INSTR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc               <= RESET_VEC;
            bus.misalign_exc <= 1'b0;
            bus.fetch_fault  <= 1'b0;
            bus.fault_addr   <= 32'd0;
            bus.fetch_count  <= 32'd0;
        end else begin
            pc               <= next_pc;
            bus.misalign_exc <= trap;
            bus.fetch_fault  <= fault ? 1'b1 : take ? 1'b0 : bus.fetch_fault;
            bus.fault_addr   <= trap ? bus.redirect_target : fault ? pc : bus.fault_addr;
            if (valid && !bus.stall && !bus.redirect_valid)
                bus.fetch_count <= bus.fetch_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_if_pc_fetch.sv
// tb_if_pc_fetch: directed plan plus randomized redirects/stalls/resets checked against a behavioural model.
module tb_if_pc_fetch;
    localparam logic [31:0] BASE = 32'h0400_0000;
    localparam logic [31:0] TRAP = 32'h0400_0100;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int M_BOOT = 0, M_RUN = 1, M_FAULT = 2;

    logic clk = 0;
    logic rst = 1;
    int   errors = 0;
    int   checks = 0;

    if_pc_fetch_if bus ();
    if_pc_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign bus.Instr = mem_word(bus.Addr);

    function automatic bit inw(input logic [31:0] a);
        longint ua = longint'(a);
        return ua >= 64'h0400_0000 && ua < 64'h0400_0000 + 4 * 1024;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    int          m_mode;
    logic [31:0] m_pc, m_fa, m_cnt;
    logic        m_mis, m_ff;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= M_BOOT; m_pc <= BASE; m_fa <= 0; m_cnt <= 0; m_mis <= 0; m_ff <= 0;
        end else if (m_mode == M_BOOT) begin
            m_mode <= M_RUN;
        end else if (m_mode == M_RUN) begin
            if (inw(m_pc) && !bus.stall && !bus.redirect_valid) m_cnt <= m_cnt + 1;
            m_mis <= bus.redirect_valid && bus.redirect_target[1:0] != 0;
            if (bus.redirect_valid && bus.redirect_target[1:0] != 0) begin
                m_pc <= TRAP; m_fa <= bus.redirect_target;
            end else if (bus.redirect_valid) begin
                m_pc <= bus.redirect_target;
            end else if (!inw(m_pc)) begin
                m_mode <= M_FAULT; m_ff <= 1; m_fa <= m_pc;
            end else if (!bus.stall) begin
                m_pc <= m_pc + 4;
            end
        end else begin
            m_mis <= bus.redirect_valid && bus.redirect_target[1:0] != 0;
            if (bus.redirect_valid && (bus.redirect_target[1:0] != 0 || inw(bus.redirect_target))) begin
                m_mode <= M_RUN; m_ff <= 0;
                m_pc <= bus.redirect_target[1:0] != 0 ? TRAP : bus.redirect_target;
                if (bus.redirect_target[1:0] != 0) m_fa <= bus.redirect_target;
            end
        end
    end

    always @(negedge clk) begin
        logic v;
        v = m_mode == M_RUN && inw(m_pc);
        chk("Addr", bus.Addr, m_pc);
        chk("if_pc", bus.if_pc, m_pc);
        chk("if_pc_plus4", bus.if_pc_plus4, m_pc + 32'd4);
        chk("if_valid", {31'd0, bus.if_valid}, {31'd0, v});
        chk("if_instr", bus.if_instr, v ? mem_word(m_pc) : NOP);
        chk("misalign_exc", {31'd0, bus.misalign_exc}, {31'd0, m_mis});
        chk("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, m_ff});
        chk("fault_addr", bus.fault_addr, m_fa);
        chk("fetch_count", bus.fetch_count, m_cnt);
    end

    task automatic redirect(input logic [31:0] t);
        #1 bus.redirect_valid = 1; bus.redirect_target = t;
    endtask

    initial begin
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_target = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("boot_addr", bus.Addr, BASE);
        chk("boot_valid", {31'd0, bus.if_valid}, 0);
        @(negedge clk);
        chk("run0_addr", bus.Addr, BASE);
        chk("run0_valid", {31'd0, bus.if_valid}, 1);
        @(negedge clk);
        chk("run1_addr", bus.Addr, 32'h0400_0004);
        @(negedge clk);
        chk("run2_addr", bus.Addr, 32'h0400_0008);
        chk("run2_count", bus.fetch_count, 2);
        #1 bus.stall = 1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_pc", bus.if_pc, 32'h0400_0008);
            chk("stall_count", bus.fetch_count, 2);
            chk("stall_plus4", bus.if_pc_plus4, 32'h0400_000C);
        end
        #1 bus.stall = 0;
        @(negedge clk);
        chk("unstall_pc", bus.if_pc, 32'h0400_000C);
        chk("unstall_count", bus.fetch_count, 3);
        #1 bus.stall = 1; redirect(32'h0400_0040);
        @(negedge clk);
        chk("redir_stall_pc", bus.if_pc, 32'h0400_0040);
        chk("redir_stall_mis", {31'd0, bus.misalign_exc}, 0);
        #1 bus.stall = 0; redirect(32'h0400_0009);
        @(negedge clk);
        chk("mis_pc", bus.if_pc, TRAP);
        chk("mis_pulse", {31'd0, bus.misalign_exc}, 1);
        chk("mis_fault_addr", bus.fault_addr, 32'h0400_0009);
        #1 bus.redirect_valid = 0;
        @(negedge clk);
        chk("mis_pulse_end", {31'd0, bus.misalign_exc}, 0);
        chk("after_trap_pc", bus.if_pc, 32'h0400_0104);
        redirect(32'h0400_0FFC);
        @(negedge clk);
        chk("edge_pc", bus.if_pc, 32'h0400_0FFC);
        chk("edge_valid", {31'd0, bus.if_valid}, 1);
        #1 bus.redirect_valid = 0;
        @(negedge clk);
        chk("oow_pc", bus.if_pc, 32'h0400_1000);
        chk("oow_valid", {31'd0, bus.if_valid}, 0);
        @(negedge clk);
        chk("fault_level", {31'd0, bus.fetch_fault}, 1);
        chk("fault_addr", bus.fault_addr, 32'h0400_1000);
        chk("fault_pc_hold", bus.if_pc, 32'h0400_1000);
        redirect(32'h0300_0000);
        @(negedge clk);
        chk("ignored_pc", bus.if_pc, 32'h0400_1000);
        chk("ignored_fault", {31'd0, bus.fetch_fault}, 1);
        redirect(BASE);
        @(negedge clk);
        chk("recover_pc", bus.if_pc, BASE);
        chk("recover_fault", {31'd0, bus.fetch_fault}, 0);
        chk("recover_valid", {31'd0, bus.if_valid}, 1);
        redirect(32'h0400_0020);
        @(negedge clk);
        chk("pre_rst_pc", bus.if_pc, 32'h0400_0020);
        #1 bus.redirect_valid = 0;
        #2 rst = 1;
        #1;
        chk("async_rst_pc", bus.if_pc, BASE);
        chk("async_rst_valid", {31'd0, bus.if_valid}, 0);
        chk("async_rst_count", bus.fetch_count, 0);
        @(negedge clk);
        #1 rst = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            bus.stall = $urandom_range(0, 3) == 0;
            bus.redirect_valid = $urandom_range(0, 9) == 0;
            case ($urandom_range(0, 5))
                0: bus.redirect_target = BASE + ($urandom_range(0, 1023) << 2);
                1: bus.redirect_target = {$urandom_range(0, 32'hFFFF) + 32'h0100_0000, $urandom_range(1, 3) == 1 ? 2'b01 : 2'b11} ^ 32'h0000_0000;
                2: bus.redirect_target = BASE + 32'h1000 - ($urandom_range(1, 4) << 2);
                3: bus.redirect_target = $urandom() & 32'hFFFF_FFFC;
                4: bus.redirect_target = BASE + 32'h1000;
                default: bus.redirect_target = BASE + ($urandom_range(0, 4095) | 32'd2);
            endcase
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1;
                @(negedge clk);
                #1 rst = 0;
            end
        end
        bus.redirect_valid = 0; bus.stall = 0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
